// File: rtl/lsu_mem_ctrl.sv
// Load/store unit memory controller for the M stage.
// Turns a load or store into one request on a simple grant/rvalid bus:
// it builds the word address, byte enables and lane-replicated store data,
// captures the read word, stalls the pipeline while the access is in
// flight, and gives up after MAX_WAIT cycles if the bus never responds.
module lsu_mem_ctrl #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReqM,
  input  logic        MemWriteM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] RD_data,
  output logic [1:0]  byteAddrM,
  output logic [2:0]  LoadTypeM,
  output logic        stallM,
  output logic        misalignM,
  output logic        timeoutM
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DONE} state_t;

  localparam logic [8:0] MAX_W9 = 9'(MAX_WAIT);

  state_t     state;
  logic [7:0] cnt;
  logic [8:0] cnt_inc;
  logic       wait_hit;
  logic       f3_ok;
  logic       aligned;
  logic       acc_ok;
  logic       idle_req;

  // Byte enables for a store, from the access size and byte offset.
  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   store_be = 4'b0001 << off;
      2'b01:   store_be = off[1] ? 4'b1100 : 4'b0011;
      default: store_be = 4'b1111;
    endcase
  endfunction

  // Store data replicated across every lane it could land in.
  function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'b00:   store_wdata = {4{d[7:0]}};
      2'b01:   store_wdata = {2{d[15:0]}};
      default: store_wdata = d;
    endcase
  endfunction

  // Classify the incoming access and derive the combinational stall/reject flags.
  always_comb begin
    f3_ok   = 1'b0;
    aligned = 1'b1;
    if (MemWriteM) begin
      f3_ok = (funct3M == 3'b000) || (funct3M == 3'b001) || (funct3M == 3'b010);
    end else begin
      f3_ok = (funct3M == 3'b000) || (funct3M == 3'b001) || (funct3M == 3'b010) ||
              (funct3M == 3'b100) || (funct3M == 3'b101);
    end
    case (funct3M[1:0])
      2'b01:   aligned = ~ALUResultM[0];
      2'b10:   aligned = (ALUResultM[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    acc_ok    = f3_ok && aligned;
    idle_req  = (state == ST_IDLE) && MemReqM && !reset;
    misalignM = idle_req && !acc_ok;
    // Reset gates these so the pipeline is released the instant reset rises.
    stallM    = !reset && ((state == ST_REQ) || (state == ST_WAIT) || (idle_req && acc_ok));
    cnt_inc   = {1'b0, cnt} + 9'd1;
    wait_hit  = (cnt_inc >= MAX_W9);
  end

  // Transaction FSM with registered bus fields, captured load results and timeout flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      RD_data    <= '0;
      byteAddrM  <= '0;
      LoadTypeM  <= '0;
      timeoutM   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          timeoutM <= 1'b0;
          if (MemReqM && acc_ok) begin
            state      <= ST_REQ;
            cnt        <= '0;
            dmem_req   <= 1'b1;
            dmem_we    <= MemWriteM;
            dmem_addr  <= {ALUResultM[31:2], 2'b00};
            dmem_be    <= MemWriteM ? store_be(funct3M[1:0], ALUResultM[1:0]) : 4'b1111;
            dmem_wdata <= MemWriteM ? store_wdata(funct3M[1:0], WriteDataM) : 32'd0;
            // Load-extender controls only follow loads; stores leave them alone.
            if (!MemWriteM) begin
              byteAddrM <= ALUResultM[1:0];
              LoadTypeM <= funct3M;
            end
          end
        end
        ST_REQ: begin
          cnt <= cnt_inc[7:0];
          if (dmem_gnt) begin
            dmem_req <= 1'b0;
            state    <= dmem_we ? ST_DONE : ST_WAIT;
          end else if (wait_hit) begin
            dmem_req <= 1'b0;
            timeoutM <= 1'b1;
            state    <= ST_DONE;
            if (!dmem_we) begin
              RD_data <= '0;
            end
          end
        end
        ST_WAIT: begin
          cnt <= cnt_inc[7:0];
          if (dmem_rvalid) begin
            RD_data <= dmem_rdata;
            state   <= ST_DONE;
          end else if (wait_hit) begin
            RD_data  <= '0;
            timeoutM <= 1'b1;
            state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          timeoutM <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: directed scenarios plus randomized accesses,
// each checked against a transaction-level model of the controller.
module tb_lsu_mem_ctrl;

  localparam int MAX_WAIT = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemReqM, MemWriteM;
  logic [2:0]  funct3M;
  logic [31:0] ALUResultM, WriteDataM;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [31:0] RD_data;
  logic [1:0]  byteAddrM;
  logic [2:0]  LoadTypeM;
  logic        stallM, misalignM, timeoutM;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] exp_rd;
  logic [1:0]  exp_ba;
  logic [2:0]  exp_lt;

  lsu_mem_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .MemReqM(MemReqM), .MemWriteM(MemWriteM), .funct3M(funct3M),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .RD_data(RD_data), .byteAddrM(byteAddrM), .LoadTypeM(LoadTypeM),
    .stallM(stallM), .misalignM(misalignM), .timeoutM(timeoutM)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // One access from an IDLE negedge through DONE, back to an IDLE negedge.
  // gd = REQ cycles before grant, rd = WAIT cycles before rvalid (99 = never).
  task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] data, input int gd, input int rd);
    logic        legal;
    logic [3:0]  ebe;
    logic [31:0] ewd, rdv;
    int          size, nat, e;
    logic        to;
    size  = 1 << (f3 % 4);
    legal = we ? (f3 <= 3'd2) : (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    if (addr % size != 0) legal = 1'b0;
    if (!we) ebe = 4'hF;
    else if (size == 1) ebe = 4'(1 << (addr % 4));
    else if (size == 2) ebe = (addr % 4 >= 2) ? 4'hC : 4'h3;
    else ebe = 4'hF;
    if (size == 1) ewd = (data % 256) * 32'h0101_0101;
    else if (size == 2) ewd = (data % 65536) * 32'h0001_0001;
    else ewd = data;

    MemReqM = 1'b1; MemWriteM = we; funct3M = f3;
    ALUResultM = addr; WriteDataM = data;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    #1;
    check_eq("idle_req_low", dmem_req, 0);
    check_eq("misalign", misalignM, !legal);
    check_eq("stall_idle", stallM, legal);
    if (!legal) begin
      @(posedge clk); @(negedge clk);
      check_eq("rej_no_req", dmem_req, 0);
      check_eq("rej_no_stall", stallM, 0);
      MemReqM = 1'b0;
      return;
    end
    if (!we) begin exp_ba = addr[1:0]; exp_lt = f3; end
    nat  = we ? gd + 1 : gd + rd + 2;
    to   = (nat > MAX_WAIT);
    e    = to ? MAX_WAIT : nat;
    rdv  = $urandom;
    @(posedge clk);
    for (int c = 0; c < e; c++) begin
      @(negedge clk);
      ALUResultM = $urandom; WriteDataM = $urandom;
      check_eq("busy_stall", stallM, 1);
      check_eq("busy_timeout", timeoutM, 0);
      check_eq("busy_misalign", misalignM, 0);
      check_eq("req_phase", dmem_req, (c <= gd));
      if (c <= gd) begin
        check_eq("addr", dmem_addr, addr & 32'hFFFF_FFFC);
        check_eq("be", dmem_be, ebe);
        check_eq("we", dmem_we, we);
        if (we) check_eq("wdata", dmem_wdata, ewd);
      end
      dmem_gnt = (c == gd) ? 1'b1 : ((c > gd) ? 1'($urandom % 2) : 1'b0);
      if (c <= gd) begin
        dmem_rvalid = 1'($urandom % 2);
        dmem_rdata  = $urandom;
      end else begin
        dmem_rvalid = (c == gd + 1 + rd);
        dmem_rdata  = dmem_rvalid ? rdv : $urandom;
      end
      @(posedge clk);
    end
    @(negedge clk);
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; MemReqM = 1'b0;
    if (!we) exp_rd = to ? 32'd0 : rdv;
    check_eq("done_stall", stallM, 0);
    check_eq("done_req", dmem_req, 0);
    check_eq("done_timeout", timeoutM, to);
    check_eq("rd_data", RD_data, exp_rd);
    check_eq("byte_addr", byteAddrM, exp_ba);
    check_eq("load_type", LoadTypeM, exp_lt);
    @(posedge clk); @(negedge clk);
    check_eq("idle_timeout_clr", timeoutM, 0);
    check_eq("idle_stall", stallM, 0);
  endtask

  initial begin
    logic [2:0] ld_f3 [5];
    ld_f3[0] = 3'd0; ld_f3[1] = 3'd1; ld_f3[2] = 3'd2; ld_f3[3] = 3'd4; ld_f3[4] = 3'd5;
    reset = 1'b1; MemReqM = 1'b0; MemWriteM = 1'b0; funct3M = 3'd0;
    ALUResultM = '0; WriteDataM = '0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    exp_rd = '0; exp_ba = '0; exp_lt = '0;
    @(negedge clk); @(negedge clk);
    check_eq("rst_req", dmem_req, 0);
    check_eq("rst_we", dmem_we, 0);
    check_eq("rst_addr", dmem_addr, 0);
    check_eq("rst_be", dmem_be, 0);
    check_eq("rst_wdata", dmem_wdata, 0);
    check_eq("rst_rd", RD_data, 0);
    check_eq("rst_ba", byteAddrM, 0);
    check_eq("rst_lt", LoadTypeM, 0);
    check_eq("rst_timeout", timeoutM, 0);
    MemReqM = 1'b1; funct3M = 3'd2; #1;
    check_eq("rst_stall_gated", stallM, 0);
    check_eq("rst_misalign", misalignM, 0);
    MemReqM = 1'b0;
    @(negedge clk); reset = 1'b0;
    @(negedge clk);

    // Directed scenarios.
    do_access(1'b0, 3'd0, 32'h0000_1003, 32'h0, 0, 0);
    check_eq("lb_hit_prev_rd", RD_data, exp_rd);
    do_access(1'b1, 3'd1, 32'h0000_2002, 32'hDEAD_BEEF, 4, 0);
    do_access(1'b0, 3'd2, 32'h0000_3001, 32'h0, 0, 0);
    do_access(1'b0, 3'd1, 32'h0000_3003, 32'h0, 0, 0);
    do_access(1'b1, 3'd2, 32'h0000_3002, 32'h1234_5678, 0, 0);
    do_access(1'b0, 3'd3, 32'h0000_3000, 32'h0, 0, 0);
    do_access(1'b1, 3'd4, 32'h0000_3000, 32'h0, 0, 0);
    do_access(1'b0, 3'd2, 32'h0000_5000, 32'h0, 0, 99);
    do_access(1'b0, 3'd4, 32'h0000_5001, 32'h0, 99, 0);
    for (int i = 0; i < 4; i++) do_access(1'b1, 3'd0, 32'h0000_6000 + i, 32'h0000_00A5 + i, 0, 0);

    // Randomized accesses; mostly legal and aligned, some rejected.
    for (int i = 0; i < 60; i++) begin
      logic        we;
      logic [2:0]  f3;
      logic [31:0] a;
      we = 1'($urandom % 2);
      if ($urandom % 8 == 0) f3 = 3'($urandom % 8);
      else f3 = we ? 3'($urandom % 3) : ld_f3[$urandom % 5];
      a = $urandom;
      if ($urandom % 8 != 0) a = a & ~(32'((1 << (f3 % 4)) - 1));
      do_access(we, f3, a, $urandom, int'($urandom % 5), int'($urandom % 5));
    end

    // Reset in WAIT, then a late grant/rvalid must have no effect.
    MemReqM = 1'b1; MemWriteM = 1'b0; funct3M = 3'd2; ALUResultM = 32'h0000_4004;
    @(posedge clk); @(negedge clk);
    dmem_gnt = 1'b1;
    @(posedge clk); @(negedge clk);
    dmem_gnt = 1'b0;
    check_eq("pre_rst_stall", stallM, 1);
    #2 reset = 1'b1;
    #1;
    check_eq("async_rst_req", dmem_req, 0);
    check_eq("async_rst_stall", stallM, 0);
    check_eq("async_rst_rd", RD_data, 0);
    check_eq("async_rst_ba", byteAddrM, 0);
    MemReqM = 1'b0;
    @(negedge clk); reset = 1'b0;
    dmem_rvalid = 1'b1; dmem_gnt = 1'b1; dmem_rdata = 32'hA5A5_A5A5;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    check_eq("late_rvalid_rd", RD_data, 0);
    check_eq("late_rvalid_req", dmem_req, 0);
    check_eq("late_rvalid_stall", stallM, 0);
    dmem_rvalid = 1'b0; dmem_gnt = 1'b0;
    exp_rd = '0; exp_ba = '0; exp_lt = '0;
    @(negedge clk);
    do_access(1'b0, 3'd5, 32'h0000_7002, 32'h0, 1, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

Interface
REQ-001 Parameter MAX_WAIT, default 15: max cycles in REQ+WAIT before timeout; legal range 1..255.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  reset, asynchronous, active-high.
REQ-004 MemReqM  in  1  M-stage instruction is a load or store.
REQ-005 MemWriteM  in  1  1 = store, 0 = load.
REQ-006 funct3M  in  3  access width/sign, RV32I encoding.
REQ-007 ALUResultM  in  32  byte address.
REQ-008 WriteDataM  in  32  store source data.
REQ-009 dmem_req, dmem_we  out  1 each  request valid; write enable.
REQ-010 dmem_addr  out  32  word-aligned address, bits [1:0] = 0.
REQ-011 dmem_be, dmem_wdata  out  4, 32  byte enables; lane-replicated store data.
REQ-012 dmem_gnt, dmem_rvalid  in  1 each  request accepted; read data valid.
REQ-013 dmem_rdata  in  32  read word.
REQ-014 RD_data, byteAddrM, LoadTypeM  out  32, 2, 3  captured read word, address[1:0], funct3 for the load extender.
REQ-015 stallM, misalignM, timeoutM  out  1 each  pipeline stall; rejected access; bus timeout.

Function
REQ-016 FSM states IDLE, REQ, WAIT, DONE shall be used.
REQ-017 IDLE with MemReqM=1 and a legal aligned access: latch dmem_addr, dmem_we, dmem_be, dmem_wdata, byteAddrM, LoadTypeM; go to REQ.
REQ-018 Misaligned: lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]!=0; illegal: funct3 011, 110, 111 for loads, or funct3 other than 000/001/010 for stores.
REQ-019 IDLE with MemReqM=1 and a misaligned or illegal access: misalignM=1 combinationally, stallM=0, no request, FSM stays in IDLE.
REQ-020 dmem_req shall be 1 exactly while in REQ; request fields held stable until dmem_gnt.
REQ-021 REQ with dmem_gnt=1: store -> DONE; load -> WAIT.
REQ-022 WAIT with dmem_rvalid=1: RD_data <= dmem_rdata; go to DONE.
REQ-023 dmem_rvalid outside WAIT shall be ignored.
REQ-024 Wait counter: cleared on IDLE->REQ, incremented each cycle in REQ or WAIT.
REQ-025 Timeout: counter reaches MAX_WAIT without the completing event -> DONE, RD_data <= 0, timeoutM=1 during DONE only.
REQ-026 stallM = 1 in REQ and WAIT, and in IDLE when a legal request is present; stallM = 0 in DONE.
REQ-027 DONE lasts one cycle, then IDLE; latency load = 3 cycles + gnt wait + rvalid wait; store = 2 cycles + gnt wait.
REQ-028 sb: be = 4'b0001 << addr[1:0], wdata = {4{WriteDataM[7:0]}}.
REQ-029 sh: be = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{WriteDataM[15:0]}}.
REQ-030 sw: be = 4'b1111, wdata = WriteDataM.
REQ-031 Loads: be = 4'b1111, dmem_we = 0.
REQ-032 RD_data, byteAddrM, LoadTypeM hold their values until the next load completes.

Reset
REQ-033 Asserting reset shall force IDLE immediately (asynchronously), dropping dmem_req and stallM, including mid-transaction.
REQ-034 Reset values: all outputs 0; wait counter 0.
REQ-035 A grant or rvalid from a transaction aborted by reset shall have no effect after reset.

Verification
REQ-036 Load hit: lb at 0x1003, gnt in REQ cycle 1, rvalid 1 cycle later with 0x80FF_FF00 -> RD_data=0x80FF_FF00, byteAddrM=3, LoadTypeM=000, dmem_addr=0x1000, stallM high 3 cycles.
REQ-037 Store sh at 0x2002, WriteDataM=0xDEAD_BEEF, gnt delayed 4 cycles -> be=1100, wdata=0xBEEF_BEEF, dmem_req held 5 cycles, stallM low in DONE.
REQ-038 Misaligned lw at 0x3001 -> misalignM=1 same cycle, dmem_req never rises, stallM=0.
REQ-039 Load with gnt but no rvalid, MAX_WAIT=15 -> DONE after 15 REQ+WAIT cycles, timeoutM=1 for 1 cycle, RD_data=0.
REQ-040 Reset asserted in WAIT, then late rvalid -> dmem_req=0 and state IDLE immediately; RD_data stays 0.
REQ-041 Back-to-back sb at addr[1:0] = 0, 1, 2, 3 -> be = 0001, 0010, 0100, 1000; a 1-cycle IDLE gap between each.
